// File: rtl/key_pkg.sv
// key_pkg -- shared definitions for the keypad decoder.
//   KEY_W      : width of a key index (4)
//   NUM_KEYS   : number of keys in the matrix (16)
//   key_evt_t  : queued event record {is_release, code}
//   lowest_set : index of the lowest set bit of a key vector (0 when none set)
package key_pkg;

    localparam int KEY_W    = 4;
    localparam int NUM_KEYS = 16;

    typedef struct packed {
        logic             is_release;
        logic [KEY_W-1:0] code;
    } key_evt_t;

    // Scanning from the top down lets the lowest set bit overwrite last.
    function automatic logic [KEY_W-1:0] lowest_set(input logic [NUM_KEYS-1:0] v);
        logic [KEY_W-1:0] idx;
        idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) idx = KEY_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// key_evt_fifo -- synchronous event FIFO with valid/ready pop side.
//   clk, rst           : clock, asynchronous active-high reset
//   push_valid         : write push_data this cycle (accepted if not full or popping)
//   push_data          : entry to store
//   full               : all DEPTH entries occupied
//   pop_valid          : head entry present (count > 0)
//   pop_ready          : consumer takes the head this cycle
//   pop_data           : head entry, forced to 0 while empty
// DEPTH must be a power of two so the pointers wrap naturally.
module key_evt_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid,
    input  logic [DATA_W-1:0] push_data,
    output logic              full,
    output logic              pop_valid,
    input  logic              pop_ready,
    output logic [DATA_W-1:0] pop_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    cnt_q, cnt_d;
    logic              do_push, do_pop;

    assign full      = (cnt_q == (PTR_W+1)'(DEPTH));
    assign pop_valid = (cnt_q != '0);
    assign pop_data  = pop_valid ? mem_q[rd_ptr_q] : '0;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_pop  = pop_valid & pop_ready;
    assign do_push = push_valid & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
            2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: reads are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/key_decode.sv
// key_decode -- debounces a 16-key scanned matrix and queues key events.
//   clk, rst     : clock, asynchronous active-high reset
//   key_raw      : raw scan, bit n low = key n pressed
//   key_state    : debounced state, bit n high = key n pressed
//   evt_valid    : event FIFO head valid
//   evt_ready    : consumer accepts head
//   evt_code     : key index of head event
//   evt_release  : head is a release event
//   ovf          : sticky, an event was merged into an already-pending one
//   ovf_clr      : synchronous clear of ovf (wins over a same-cycle set)
// Build option: define KEY_DECODE_RELEASE_EVT_EN to queue release events
// as well as presses; otherwise only presses are queued and evt_release is 0.
module key_decode
    import key_pkg::*;
#(
    parameter int SAMPLE_DIV = 1000,
    parameter int STABLE_CNT = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_state,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [KEY_W-1:0]    evt_code,
    output logic                evt_release,
    output logic                ovf,
    input  logic                ovf_clr
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    // ---------------- sample strobe and debounce ----------------
    logic [DIV_W-1:0]              div_q, div_d;
    logic                          strobe;
    logic [NUM_KEYS-1:0][3:0]      cnt_q, cnt_d;
    logic [NUM_KEYS-1:0]           key_state_q, key_state_d;
    logic [NUM_KEYS-1:0]           key_prev_q;

    assign strobe = (div_q == DIV_W'(SAMPLE_DIV - 1));

    always_comb begin
        div_d       = strobe ? '0 : div_q + DIV_W'(1);
        cnt_d       = cnt_q;
        key_state_d = key_state_q;
        if (strobe) begin
            for (int n = 0; n < NUM_KEYS; n++) begin
                if (~key_raw[n] != key_state_q[n]) begin
                    // Flip on the strobe that would bring the count to STABLE_CNT.
                    if (cnt_q[n] == 4'(STABLE_CNT - 1)) begin
                        key_state_d[n] = ~key_state_q[n];
                        cnt_d[n]       = '0;
                    end else begin
                        cnt_d[n] = cnt_q[n] + 4'd1;
                    end
                end else begin
                    cnt_d[n] = '0;
                end
            end
        end
    end

    assign key_state = key_state_q;

    // ---------------- pending bits and encoder ----------------
    logic [NUM_KEYS-1:0] rise, sel_oh, press_clr;
    logic [NUM_KEYS-1:0] press_pend_q, press_pend_d;
    logic                press_any, push, pop_fire, fifo_full, fifo_valid;
    logic [KEY_W-1:0]    sel_code;
    logic                ovf_q, ovf_d, ovf_set;

    assign rise     = key_state_q & ~key_prev_q;
    assign pop_fire = fifo_valid & evt_ready;

`ifdef KEY_DECODE_RELEASE_EVT_EN
    logic [NUM_KEYS-1:0] fall, rel_clr;
    logic [NUM_KEYS-1:0] release_pend_q, release_pend_d;
    logic                rel_any;
    key_evt_t            push_evt, head_evt;

    assign fall = ~key_state_q & key_prev_q;
`endif

    always_comb begin
        press_any = |press_pend_q;
`ifdef KEY_DECODE_RELEASE_EVT_EN
        rel_any  = |release_pend_q;
        sel_code = press_any ? lowest_set(press_pend_q) : lowest_set(release_pend_q);
        push     = (press_any | rel_any) & (~fifo_full | pop_fire);
`else
        sel_code = lowest_set(press_pend_q);
        push     = press_any & (~fifo_full | pop_fire);
`endif
        sel_oh    = {{(NUM_KEYS-1){1'b0}}, 1'b1} << sel_code;
        press_clr = (push & press_any) ? sel_oh : '0;
        // A bit being encoded this cycle is no longer pending, so a new
        // transition on it re-arms cleanly instead of counting as a merge.
        press_pend_d = (press_pend_q & ~press_clr) | rise;
        ovf_set      = |(rise & press_pend_q & ~press_clr);
`ifdef KEY_DECODE_RELEASE_EVT_EN
        rel_clr        = (push & ~press_any) ? sel_oh : '0;
        release_pend_d = (release_pend_q & ~rel_clr) | fall;
        ovf_set        = ovf_set | (|(fall & release_pend_q & ~rel_clr));
`endif
        ovf_d = ovf_clr ? 1'b0 : (ovf_q | ovf_set);
    end

    assign ovf = ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q          <= '0;
            cnt_q          <= '0;
            key_state_q    <= '0;
            key_prev_q     <= '0;
            press_pend_q   <= '0;
            ovf_q          <= 1'b0;
`ifdef KEY_DECODE_RELEASE_EVT_EN
            release_pend_q <= '0;
`endif
        end else begin
            div_q          <= div_d;
            cnt_q          <= cnt_d;
            key_state_q    <= key_state_d;
            key_prev_q     <= key_state_q;
            press_pend_q   <= press_pend_d;
            ovf_q          <= ovf_d;
`ifdef KEY_DECODE_RELEASE_EVT_EN
            release_pend_q <= release_pend_d;
`endif
        end
    end

    // ---------------- event FIFO ----------------
`ifdef KEY_DECODE_RELEASE_EVT_EN
    assign push_evt.is_release = ~press_any;
    assign push_evt.code       = sel_code;

    key_evt_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W ($bits(key_evt_t))
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push),
        .push_data  (push_evt),
        .full       (fifo_full),
        .pop_valid  (fifo_valid),
        .pop_ready  (evt_ready),
        .pop_data   (head_evt)
    );

    assign evt_code    = head_evt.code;
    assign evt_release = head_evt.is_release;
`else
    key_evt_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (KEY_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push),
        .push_data  (sel_code),
        .full       (fifo_full),
        .pop_valid  (fifo_valid),
        .pop_ready  (evt_ready),
        .pop_data   (evt_code)
    );

    assign evt_release = 1'b0;
`endif

    assign evt_valid = fifo_valid;

endmodule

// File: tb/tb_key_decode.sv
// tb_key_decode -- scoreboard bench for key_decode (SAMPLE_DIV=4,
// STABLE_CNT=3, FIFO_DEPTH=4). Expected events are queued as keys are
// driven and compared by a monitor as the DUT hands them over.
module tb_key_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] key_raw;
    logic [15:0] key_state;
    logic        evt_valid;
    logic        evt_ready;
    logic [3:0]  evt_code;
    logic        evt_release;
    logic        ovf;
    logic        ovf_clr;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [4:0]  exp_q[$];
    logic [31:0] mon_exp;

    key_decode #(
        .SAMPLE_DIV (4),
        .STABLE_CNT (3),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_raw     (key_raw),
        .key_state   (key_state),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_code    (evt_code),
        .evt_release (evt_release),
        .ovf         (ovf),
        .ovf_clr     (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Handshake is decided at the next rising edge; inputs only change
    // 1 time unit after a rising edge, so the negedge view is final.
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            mon_exp = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hDEAD;
            chk("evt", 32'({evt_release, evt_code}), mon_exp);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        key_raw   = '1;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        rst       = 1'b1;
        cyc(2);
        exp_q.delete();
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic press(input int k);
        key_raw[k] = 1'b0;
        exp_q.push_back(5'(k));
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) cyc(1);
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        key_raw   = '1;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        rst       = 1'b1;
        cyc(3);
        @(negedge clk);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_code",  32'(evt_code), 32'd0);
        chk("rst_rel",   32'(evt_release), 32'd0);
        chk("rst_state", 32'(key_state), 32'd0);
        chk("rst_ovf",   32'(ovf), 32'd0);

        // Single press of key 5.
        do_reset();
        evt_ready = 1'b1;
        press(5);
        cyc(30);
        chk("k5_state", 32'(key_state), 32'h0020);
        drain("k5_drain");

        // Key 5 bouncing once per strobe never settles.
        do_reset();
        evt_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            key_raw[5] = ~key_raw[5];
            cyc(4);
        end
        cyc(10);
        chk("bounce_state", 32'(key_state), 32'h0000);
        chk("bounce_valid", 32'(evt_valid), 32'd0);
        chk("bounce_ovf",   32'(ovf), 32'd0);

        // Three keys on the same strobe come out lowest index first.
        do_reset();
        evt_ready = 1'b1;
        key_raw[9] = 1'b0; key_raw[2] = 1'b0; key_raw[12] = 1'b0;
        exp_q.push_back(5'd2); exp_q.push_back(5'd9); exp_q.push_back(5'd12);
        cyc(30);
        chk("multi_state", 32'(key_state), 32'h1204);
        drain("multi_drain");

        // Six presses into a 4-deep FIFO with the consumer stalled.
        do_reset();
        press(0); press(1); press(4); press(8); press(10); press(15);
        cyc(30);
        chk("full_valid", 32'(evt_valid), 32'd1);
        chk("full_head",  32'(evt_code), 32'd0);
        chk("full_ovf",   32'(ovf), 32'd0);
        cyc(10);
        chk("full_hold",  32'(evt_code), 32'd0);
        evt_ready = 1'b1;
        drain("full_drain");
        chk("full_ovf2",  32'(ovf), 32'd0);

`ifndef KEY_DECODE_RELEASE_EVT_EN
        // Key 3 re-pressed while its first press is still pending.
        do_reset();
        press(0); press(1); press(2); press(4);
        cyc(30);
        press(3);
        cyc(30);
        key_raw[3] = 1'b1;
        cyc(30);
        chk("merge_rel_state", 32'(key_state[3]), 32'd0);
        chk("merge_ovf_pre",   32'(ovf), 32'd0);
        key_raw[3] = 1'b0;
        cyc(30);
        chk("merge_ovf", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        chk("merge_ovf_clr", 32'(ovf), 32'd0);
        evt_ready = 1'b1;
        drain("merge_drain");
`else
        // Press then release of key 7 yields both events.
        do_reset();
        evt_ready = 1'b1;
        press(7);
        cyc(30);
        key_raw[7] = 1'b1;
        exp_q.push_back(5'h17);
        cyc(30);
        chk("rel_state", 32'(key_state), 32'h0000);
        drain("rel_drain");
`endif

        // Reset while events are queued discards them.
        do_reset();
        key_raw[1] = 1'b0; key_raw[2] = 1'b0;
        cyc(30);
        chk("mid_valid", 32'(evt_valid), 32'd1);
        rst = 1'b1;
        key_raw = '1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(evt_valid), 32'd0);
        chk("mid_rst_state", 32'(key_state), 32'h0000);
        evt_ready = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(30);
        chk("mid_after_valid", 32'(evt_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
